// File: rtl/sobel_window_scheduler.sv
// -----------------------------------------------------------------------------
// sobel_window_scheduler
//
// Walks every interior pixel of an IMG_W x IMG_H frame held in a
// synchronous-read pixel memory. For each pixel it performs these steps:
//   - issues the nine 3x3 neighbourhood reads,
//   - tags the returning data with its tap index,
//   - strobes the convolver once all nine taps are in,
//   - hands the result to the sink.
// isEnd tells the top-level controller that the frame is complete.
//
// Ports
//   CLK       clock, every register updates on the rising edge
//   RST       synchronous active-high reset, wins over everything
//   Start     frame start request, only looked at in IDLE
//   RdEn      pixel memory read strobe (FETCH only)
//   RdAddr    pixel memory read address, 0 when RdEn is low
//   TapValid  memory output carries the tap named by TapIdx this cycle
//   TapIdx    tap number 0..8, row-major over the 3x3 window
//   Compute   one-cycle strobe, all nine taps have been delivered
//   WrEn      result write request, held until accepted
//   WrAddr    result address (input-frame indexing), 0 when WrEn is low
//   WrReady   sink accepts the result when WrEn && WrReady
//   Busy      high in every state except IDLE
//   isEnd     one-cycle pulse after the last result write is accepted
//   dbg_state current FSM state (state_t encoding) for observation
//
// Handshake: a result transfer happens on a rising edge where WrEn and
// WrReady are both high. Once WrEn rises, WrEn and WrAddr stay constant
// until that edge. The scheduler waits as long as needed. WrReady is
// ignored while WrEn is low.
// -----------------------------------------------------------------------------
module sobel_window_scheduler #(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Start,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  output logic              TapValid,
  output logic [3:0]        TapIdx,
  output logic              Compute,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  input  logic              WrReady,
  output logic              Busy,
  output logic              isEnd,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_COMPUTE = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  // Counter widths only need to reach IMG_H-2 / IMG_W-2.
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [ROW_W-1:0]  ROW_FIRST = ROW_W'(1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 2);
  localparam logic [COL_W-1:0]  COL_FIRST = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 2);
  localparam logic [3:0]        TAP_LAST  = 4'd8;
  localparam logic [ADDR_W-1:0] IMG_W_A   = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);

  state_t           state, state_next;
  logic [ROW_W-1:0] row, row_next;
  logic [COL_W-1:0] col, col_next;
  logic [3:0]       tap, tap_next;
  logic             tap_valid_q;
  logic [3:0]       tap_idx_q;

  logic             rd_en;
  logic [1:0]       tap_dy;
  logic [1:0]       tap_dx;
  logic [ADDR_W-1:0] row_a, col_a, rd_row_a, rd_col_a;
  logic [ADDR_W-1:0] rd_addr_calc, wr_addr_calc;
  logic              last_pixel;

  // ---------------------------------------------------------------------------
  // State, counters and the one-cycle tap tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      tap         <= '0;
      tap_valid_q <= 1'b0;
      tap_idx_q   <= '0;
    end else begin
      state       <= state_next;
      row         <= row_next;
      col         <= col_next;
      tap         <= tap_next;
      // Memory has one cycle of read latency, so the tag trails the read.
      tap_valid_q <= rd_en;
      tap_idx_q   <= rd_en ? tap : 4'd0;
    end
  end

  assign last_pixel = (row == ROW_LAST) && (col == COL_LAST);

  // ---------------------------------------------------------------------------
  // Next-state and counter update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    row_next   = row;
    col_next   = col;
    tap_next   = tap;
    case (state)
      S_IDLE: begin
        if (Start) begin
          state_next = S_FETCH;
          row_next   = ROW_FIRST;
          col_next   = COL_FIRST;
          tap_next   = 4'd0;
        end
      end
      S_FETCH: begin
        if (tap == TAP_LAST) begin
          state_next = S_WAIT;
        end else begin
          tap_next = tap + 4'd1;
        end
      end
      S_WAIT: begin
        // Data for tap 8 is on the memory output during this cycle.
        state_next = S_COMPUTE;
      end
      S_COMPUTE: begin
        state_next = S_WRITE;
      end
      S_WRITE: begin
        if (WrReady) begin
          if (last_pixel) begin
            state_next = S_DONE;
          end else begin
            state_next = S_FETCH;
            tap_next   = 4'd0;
            if (col == COL_LAST) begin
              col_next = COL_FIRST;
              row_next = row + ROW_W'(1);
            end else begin
              col_next = col + COL_W'(1);
            end
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tap number -> window offset (row-major 3x3), avoids a divider
  // ---------------------------------------------------------------------------
  always_comb begin
    tap_dy = 2'd0;
    tap_dx = 2'd0;
    case (tap)
      4'd0: begin tap_dy = 2'd0; tap_dx = 2'd0; end
      4'd1: begin tap_dy = 2'd0; tap_dx = 2'd1; end
      4'd2: begin tap_dy = 2'd0; tap_dx = 2'd2; end
      4'd3: begin tap_dy = 2'd1; tap_dx = 2'd0; end
      4'd4: begin tap_dy = 2'd1; tap_dx = 2'd1; end
      4'd5: begin tap_dy = 2'd1; tap_dx = 2'd2; end
      4'd6: begin tap_dy = 2'd2; tap_dx = 2'd0; end
      4'd7: begin tap_dy = 2'd2; tap_dx = 2'd1; end
      4'd8: begin tap_dy = 2'd2; tap_dx = 2'd2; end
      default: begin tap_dy = 2'd0; tap_dx = 2'd0; end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Address generation. row and col are always >= 1 while in use, so the
  // "-1" window offset never underflows and every read stays in-frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    row_a        = ADDR_W'(row);
    col_a        = ADDR_W'(col);
    rd_row_a     = row_a + ADDR_W'(tap_dy) - ONE_A;
    rd_col_a     = col_a + ADDR_W'(tap_dx) - ONE_A;
    rd_addr_calc = rd_row_a * IMG_W_A + rd_col_a;
    wr_addr_calc = row_a * IMG_W_A + col_a;
  end

  // ---------------------------------------------------------------------------
  // Outputs: strobes decode straight from state, so they are mutually
  // exclusive by construction. Addresses are zeroed when not in use.
  // ---------------------------------------------------------------------------
  assign rd_en     = (state == S_FETCH);
  assign RdEn      = rd_en;
  assign RdAddr    = rd_en ? rd_addr_calc : '0;
  assign TapValid  = tap_valid_q;
  assign TapIdx    = tap_idx_q;
  assign Compute   = (state == S_COMPUTE);
  assign WrEn      = (state == S_WRITE);
  assign WrAddr    = (state == S_WRITE) ? wr_addr_calc : '0;
  assign Busy      = (state != S_IDLE);
  assign isEnd     = (state == S_DONE);
  assign dbg_state = state;

endmodule
